// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus used by the memory-stage load/store unit.
interface mem_access_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/mem_access.sv
// Memory-stage load/store unit: issues one bus transaction per load/store,
// steers big-endian byte lanes, extends load data, stalls the pipeline while
// the access is outstanding and drives the registered MEM/WB outputs.
module mem_access #(
  parameter int ACK_TIMEOUT = 255,  // 0 disables the ack watchdog
  parameter int TMR_W       = 8
) (
  input  logic          clk,
  input  logic          rst,        // asynchronous, active-low
  input  logic [7:0]    aluop_i,
  input  logic [31:0]   mem_addr_i,
  input  logic [31:0]   reg2_i,
  input  logic [4:0]    wd_i,
  input  logic          wreg_i,
  input  logic [31:0]   wdata_i,
  output logic [4:0]    wd_o,
  output logic          wreg_o,
  output logic [31:0]   wdata_o,
  output logic          stallreq,
  mem_access_if.master  bus,
  output logic          misalign_o,
  output logic          bus_err_o
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Count value on which the last ack-less BUSY cycle times out.
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((ACK_TIMEOUT > 0) ? (ACK_TIMEOUT - 1) : 0);

  // Select the addressed lane of the read word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [7:0] op,
                                              input logic [1:0] lane,
                                              input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = lane[1] ? d[15:0] : d[31:16];
    case (op)
      OP_LB:   load_extend = {{24{b[7]}}, b};
      OP_LBU:  load_extend = {24'h00_0000, b};
      OP_LH:   load_extend = {{16{h[15]}}, h};
      OP_LHU:  load_extend = {16'h0000, h};
      default: load_extend = d;
    endcase
  endfunction

  logic             is_mem_s, is_store_s, aligned_s;
  logic [1:0]       size_s;   // 0 byte, 1 half, 2 word
  logic [3:0]       sel_s;
  logic [31:0]      st_data_s;

  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic [7:0]       op_q, op_d;
  logic [1:0]       lane_q, lane_d;
  logic [4:0]       swd_q, swd_d;
  logic             swreg_q, swreg_d;
  logic [4:0]       wd_q, wd_d;
  logic             wreg_q, wreg_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             req_q, req_d, we_q, we_d;
  logic [31:0]      addr_q, addr_d, data_q, data_d;
  logic [3:0]       sel_q, sel_d;
  logic             mis_q, mis_d, berr_q, berr_d;

  // Decode the EX op into access size, direction, alignment and lane pattern.
  always_comb begin
    is_mem_s   = 1'b1;
    is_store_s = 1'b0;
    size_s     = 2'd0;
    case (aluop_i)
      OP_LB, OP_LBU: size_s = 2'd0;
      OP_LH, OP_LHU: size_s = 2'd1;
      OP_LW:         size_s = 2'd2;
      OP_SB:         begin size_s = 2'd0; is_store_s = 1'b1; end
      OP_SH:         begin size_s = 2'd1; is_store_s = 1'b1; end
      OP_SW:         begin size_s = 2'd2; is_store_s = 1'b1; end
      default:       is_mem_s = 1'b0;
    endcase
    case (size_s)
      2'd0: begin
        aligned_s = 1'b1;
        sel_s     = 4'b1000 >> mem_addr_i[1:0];
        st_data_s = {4{reg2_i[7:0]}};
      end
      2'd1: begin
        aligned_s = ~mem_addr_i[0];
        sel_s     = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        st_data_s = {2{reg2_i[15:0]}};
      end
      default: begin
        aligned_s = (mem_addr_i[1:0] == 2'b00);
        sel_s     = 4'b1111;
        st_data_s = reg2_i;
      end
    endcase
  end

  // Stall while an aligned access is being issued or is outstanding; held low in reset.
  assign stallreq = rst & ((state_q == S_BUSY) |
                           ((state_q == S_IDLE) & is_mem_s & aligned_s));

  // Next-state logic for the access FSM, bus request and write-back registers.
  always_comb begin
    state_d = state_q;  cnt_d   = cnt_q;   op_d    = op_q;    lane_d  = lane_q;
    swd_d   = swd_q;    swreg_d = swreg_q; wd_d    = wd_q;    wreg_d  = wreg_q;
    wdata_d = wdata_q;  req_d   = req_q;   we_d    = we_q;    addr_d  = addr_q;
    data_d  = data_q;   sel_d   = sel_q;   mis_d   = 1'b0;    berr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mem_s) begin
          wreg_d = 1'b0;
          if (aligned_s) begin
            req_d   = 1'b1;
            we_d    = is_store_s;
            addr_d  = {mem_addr_i[31:2], 2'b00};
            sel_d   = sel_s;
            data_d  = st_data_s;
            swd_d   = wd_i;
            swreg_d = wreg_i;
            op_d    = aluop_i;
            lane_d  = mem_addr_i[1:0];
            cnt_d   = {TMR_W{1'b0}};
            state_d = S_BUSY;
          end else begin
            mis_d = 1'b1;
          end
        end else begin
          wd_d    = wd_i;
          wreg_d  = wreg_i;
          wdata_d = wdata_i;
        end
      end
      S_BUSY: begin
        if (bus.mem_ack_i) begin
          req_d   = 1'b0;
          cnt_d   = {TMR_W{1'b0}};
          state_d = S_DONE;
          if (we_q) begin
            wreg_d = 1'b0;
          end else begin
            wd_d    = swd_q;
            wreg_d  = swreg_q;
            wdata_d = load_extend(op_q, lane_q, bus.mem_data_i);
          end
        end else if ((ACK_TIMEOUT != 0) && (cnt_q == TMO_LAST)) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          wreg_d  = 1'b0;
          cnt_d   = {TMR_W{1'b0}};
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + TMR_W'(1);
        end
      end
      S_DONE: begin
        wreg_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        wreg_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything, dropping any request at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;      cnt_q   <= {TMR_W{1'b0}}; op_q    <= 8'h00;
      lane_q  <= 2'b00;       swd_q   <= 5'd0;          swreg_q <= 1'b0;
      wd_q    <= 5'd0;        wreg_q  <= 1'b0;          wdata_q <= 32'h0;
      req_q   <= 1'b0;        we_q    <= 1'b0;          addr_q  <= 32'h0;
      data_q  <= 32'h0;       sel_q   <= 4'b0000;       mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;     cnt_q   <= cnt_d;         op_q    <= op_d;
      lane_q  <= lane_d;      swd_q   <= swd_d;         swreg_q <= swreg_d;
      wd_q    <= wd_d;        wreg_q  <= wreg_d;        wdata_q <= wdata_d;
      req_q   <= req_d;       we_q    <= we_d;          addr_q  <= addr_d;
      data_q  <= data_d;      sel_q   <= sel_d;         mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign wd_o           = wd_q;
  assign wreg_o         = wreg_q;
  assign wdata_o        = wdata_q;
  assign misalign_o     = mis_q;
  assign bus_err_o      = berr_q;
  assign bus.mem_req_o  = req_q;
  assign bus.mem_we_o   = we_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_sel_o  = sel_q;
  assign bus.mem_data_o = data_q;

endmodule
